writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL take parameters, one per line:
- W, 8, data width.
- A, 2, register address width.
- DEPTH, 4, queue entries (power of two, at least 2).

REQ-002 The block SHALL have these ports, one per line:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- AluValid  in  1  ALU result offered.
- AluReady  out  1  ALU result accepted this cycle when AluValid is also high.
- AluAddr  in  A  ALU destination register.
- AluData  in  W  ALU result.
- AluJump  in  1  result targets the jump register.
- LdValid  in  1  load result offered.
- LdReady  out  1  load result accepted this cycle when LdValid is also high.
- LdAddr  in  A  load destination register.
- LdData  in  W  load data.
- WriteEn  out  1  register-file write strobe.
- Waddr  out  A  register-file write address.
- DataIn  out  W  register-file write data.
- Jump  out  1  register-file jump-write qualifier.
- QueryAddr  in  A  hazard probe address.
- QueryPending  out  1  a queued write targets QueryAddr.
- Count  out  $clog2(DEPTH+1)  current occupancy.

REQ-003 Reset is Reset, synchronous, active-high; the clock is Clk.

Function
REQ-004 Each queue entry SHALL hold {jump, addr, data}, stored in FIFO order.
REQ-005 Free slots SHALL be computed as DEPTH-Count using Count at the start of the cycle; a pop in the same cycle SHALL NOT create room for a push.
REQ-006 LdReady SHALL be high when free >= 1, and AluReady SHALL be high when free >= 2, or when free = 1 and LdValid = 0.
- Priority: load wins a single free slot.
REQ-007 When both sources are accepted in one cycle, the load entry SHALL be enqueued before the ALU entry.
REQ-008 While the queue is non-empty, WriteEn SHALL be 1 and Waddr, DataIn and Jump SHALL present the head entry combinationally; the head SHALL pop on that clock edge unconditionally.
REQ-009 While the queue is empty, WriteEn, Waddr, DataIn and Jump SHALL all be 0; there SHALL be no bypass from input to output in the same cycle.
REQ-010 Latency SHALL be as follows: an entry accepted at edge k, into an empty queue, drives WriteEn in cycle k..k+1 and is written by the register file at edge k+1.
REQ-011 Jump SHALL equal the head's jump bit and SHALL be meaningful only while WriteEn = 1.
REQ-012 Count SHALL update each edge as Count + pushes - pop, with pushes in 0..2 and pop in 0..1, and SHALL stay within 0..DEPTH.
REQ-013 Read and write pointers SHALL wrap modulo DEPTH, with no bubble at wrap-around.
REQ-014 QueryPending SHALL be the combinational OR over occupied entries of (addr == QueryAddr && !jump).
- It SHALL exclude the entry being accepted in the current cycle.
REQ-015 Input fields SHALL be sampled only on an accepted handshake; they are don't-care otherwise.
REQ-016 When the queue is full, both Ready outputs SHALL be 0 even though a pop occurs in that cycle.

Reset
REQ-017 When Reset = 1 at an edge, pointers and Count SHALL go to 0 and all entries SHALL be invalidated.
- Queued writes are discarded, not drained.
REQ-018 During a cycle in which Reset is high, AluReady and LdReady SHALL be 0; no handshake SHALL complete.
REQ-019 After reset, WriteEn, Waddr, DataIn, Jump, QueryPending and Count SHALL all read 0.

Structure
REQ-020 Package wb_pkg SHALL hold the entry struct typedef (jump, addr[A], data[W]) and the default constants W=8, A=2, DEPTH=4.
REQ-021 Storage SHALL be a sub-module wb_fifo with 2-write/1-read ports, pointer and Count logic, and an occupancy vector for the query.
- Arbitration, the Ready logic and the query comparator SHALL stay in writeback_unit.

Verification
REQ-022 Single load, LdAddr=2, LdData=0x5A, on an idle queue -> next cycle WriteEn=1, Waddr=2, DataIn=0x5A, Jump=0; following cycle WriteEn=0, Count=0.
REQ-023 Both sources valid on an empty queue, Ld (1, 0x11) and Alu (3, 0x22) -> Count=2 after the edge, then writes occur in order (1, 0x11) then (3, 0x22) on consecutive cycles.
REQ-024 Fill the queue to Count=3 with both sources valid -> LdReady=1 and AluReady=0, the load is enqueued, and with the pop Count stays 3.
REQ-025 AluJump=1, AluData=0x40 -> WriteEn=1, Jump=1, DataIn=0x40; QueryPending stays 0 when QueryAddr equals that entry's addr.
REQ-026 Queue holding entries for addresses 0 and 2 -> QueryPending=1 for QueryAddr=2 and 0 for QueryAddr=1; assert Reset for one cycle -> Count=0, WriteEn=0, QueryPending=0, and the discarded writes never appear.
REQ-027 Run 4+DEPTH cycles of back-to-back dual pushes -> the pointers wrap, the output order matches the push order exactly, and Count never exceeds DEPTH.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback unit.
// Holds the default geometry (data width, register address width, queue depth),
// the queue entry layout, and a helper that gives the packed entry width.
package wb_pkg;

    localparam int unsigned WB_W     = 8;
    localparam int unsigned WB_A     = 2;
    localparam int unsigned WB_DEPTH = 4;

    // One pending register-file write, stored in FIFO order.
    typedef struct packed {
        logic            jump;
        logic [WB_A-1:0] addr;
        logic [WB_W-1:0] data;
    } wb_entry_t;

    // Packed width of {jump, addr, data} for arbitrary widths.
    function automatic int unsigned wb_entry_width(input int unsigned w, input int unsigned a);
        return 1 + a + w;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Writeback queue storage: 2-write / 1-read FIFO with occupancy tracking.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   push_num_i            number of entries written this edge (0..2)
//   wdata0_i, wdata1_i    entries in enqueue order (wdata1_i used only when push_num_i == 2)
//   pop_i                 retire the head entry this edge
//   head_o                entry at the read pointer
//   count_o               current occupancy
//   occ_o                 per-slot occupied flags
//   mem_o                 raw slot contents (for the hazard query)
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned EW    = wb_entry_width(WB_W, WB_A),
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [1:0]                    push_num_i,
    input  logic [EW-1:0]                 wdata0_i,
    input  logic [EW-1:0]                 wdata1_i,
    input  logic                          pop_i,
    output logic [EW-1:0]                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic [DEPTH-1:0]              occ_o,
    output logic [DEPTH-1:0][EW-1:0]      mem_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][EW-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]         occ_q, occ_d;
    logic [PW-1:0]            wptr_q, wptr_d;
    logic [PW-1:0]            rptr_q, rptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [PW-1:0]            wptr_nxt;

    // DEPTH is a power of two, so plain PW-bit arithmetic wraps the pointers.
    assign wptr_nxt = wptr_q + PW'(1);

    always_comb begin
        mem_d   = mem_q;
        occ_d   = occ_q;
        wptr_d  = wptr_q + PW'(push_num_i);
        rptr_d  = rptr_q;
        count_d = count_q + CW'(push_num_i) - CW'(pop_i);
        // Clear before set: a push never lands on the slot being popped because the
        // unit only pushes into slots that were free at the start of the cycle.
        if (pop_i) begin
            occ_d[rptr_q] = 1'b0;
            rptr_d        = rptr_q + PW'(1);
        end
        if (push_num_i != 2'd0) begin
            mem_d[wptr_q] = wdata0_i;
            occ_d[wptr_q] = 1'b1;
        end
        if (push_num_i == 2'd2) begin
            mem_d[wptr_nxt] = wdata1_i;
            occ_d[wptr_nxt] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            occ_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            occ_q   <= occ_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Slot contents need no reset; they are qualified by occ_q everywhere.
    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign occ_o   = occ_q;
    assign mem_o   = mem_q;

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: merges ALU and load results into a small queue that drains one
// register-file write per cycle, and answers hazard probes against queued writes.
// Ports:
//   Clk, Reset                         clock, synchronous active-high reset
//   AluValid/AluReady/AluAddr/AluData/AluJump   ALU result handshake
//   LdValid/LdReady/LdAddr/LdData      load result handshake
//   WriteEn/Waddr/DataIn/Jump          register-file write port (head of queue)
//   QueryAddr/QueryPending             hazard probe: a queued non-jump write targets QueryAddr
//   Count                              current queue occupancy
module writeback_unit
    import wb_pkg::*;
#(
    parameter int unsigned W     = WB_W,
    parameter int unsigned A     = WB_A,
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       AluValid,
    output logic                       AluReady,
    input  logic [A-1:0]               AluAddr,
    input  logic [W-1:0]               AluData,
    input  logic                       AluJump,
    input  logic                       LdValid,
    output logic                       LdReady,
    input  logic [A-1:0]               LdAddr,
    input  logic [W-1:0]               LdData,
    output logic                       WriteEn,
    output logic [A-1:0]               Waddr,
    output logic [W-1:0]               DataIn,
    output logic                       Jump,
    input  logic [A-1:0]               QueryAddr,
    output logic                       QueryPending,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int unsigned EW = wb_entry_width(W, A);
    localparam int unsigned CW = $clog2(DEPTH+1);

    // Same layout as wb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic         jump;
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } entry_t;

    logic [CW-1:0]            free;
    logic                     ld_acc, alu_acc;
    logic [1:0]               push_num;
    entry_t                   ld_entry, alu_entry, wdata0, wdata1, head;
    logic [EW-1:0]            head_raw;
    logic [DEPTH-1:0]         occ;
    logic [DEPTH-1:0][EW-1:0] mem;
    entry_t                   slot [DEPTH];

    // Free space uses the occupancy at the start of the cycle; a same-cycle pop
    // does not make room, so a full queue refuses both sources.
    assign free     = CW'(DEPTH) - Count;
    assign LdReady  = !Reset && (free >= CW'(1));
    assign AluReady = !Reset && ((free >= CW'(2)) || ((free == CW'(1)) && !LdValid));

    assign ld_acc  = LdValid && LdReady;
    assign alu_acc = AluValid && AluReady;

    assign ld_entry  = '{jump: 1'b0, addr: LdAddr, data: LdData};
    assign alu_entry = '{jump: AluJump, addr: AluAddr, data: AluData};

    // Load goes first when both are accepted.
    always_comb begin
        push_num = 2'(ld_acc) + 2'(alu_acc);
        wdata0   = ld_acc ? ld_entry : alu_entry;
        wdata1   = alu_entry;
    end

    wb_fifo #(
        .EW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk        (Clk),
        .Reset      (Reset),
        .push_num_i (push_num),
        .wdata0_i   (wdata0),
        .wdata1_i   (wdata1),
        .pop_i      (WriteEn),
        .head_o     (head_raw),
        .count_o    (Count),
        .occ_o      (occ),
        .mem_o      (mem)
    );

    // The head is written (and popped) every cycle the queue is non-empty.
    always_comb begin
        head    = entry_t'(head_raw);
        WriteEn = (Count != '0);
        Waddr   = WriteEn ? head.addr : '0;
        DataIn  = WriteEn ? head.data : '0;
        Jump    = WriteEn ? head.jump : 1'b0;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot[i] = entry_t'(mem[i]);
        end
    end

    // Jump-register writes never create a GPR hazard.
    always_comb begin
        QueryPending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && (slot[i].addr == QueryAddr) && !slot[i].jump) begin
                QueryPending = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
    import wb_pkg::*;

    localparam int unsigned W     = 8;
    localparam int unsigned A     = 2;
    localparam int unsigned DEPTH = 4;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         AluValid = 1'b0, AluJump = 1'b0, LdValid = 1'b0;
    logic         AluReady, LdReady;
    logic [A-1:0] AluAddr = '0, LdAddr = '0, QueryAddr = '0;
    logic [W-1:0] AluData = '0, LdData = '0;
    logic         WriteEn, Jump, QueryPending;
    logic [A-1:0] Waddr;
    logic [W-1:0] DataIn;
    logic [2:0]   Count;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // mdl: what the queue holds; exp_q: writes the register file should still see.
    wb_entry_t mdl[$];
    wb_entry_t exp_q[$];

    always #5 Clk = ~Clk;

    writeback_unit #(
        .W     (W),
        .A     (A),
        .DEPTH (DEPTH)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .AluValid     (AluValid),
        .AluReady     (AluReady),
        .AluAddr      (AluAddr),
        .AluData      (AluData),
        .AluJump      (AluJump),
        .LdValid      (LdValid),
        .LdReady      (LdReady),
        .LdAddr       (LdAddr),
        .LdData       (LdData),
        .WriteEn      (WriteEn),
        .Waddr        (Waddr),
        .DataIn       (DataIn),
        .Jump         (Jump),
        .QueryAddr    (QueryAddr),
        .QueryPending (QueryPending),
        .Count        (Count)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; called just after a rising edge.
    task automatic step(input logic ldv, input logic [A-1:0] lda, input logic [W-1:0] ldd,
                        input logic aluv, input logic [A-1:0] alua, input logic [W-1:0] alud,
                        input logic aluj, input logic rst, input logic [A-1:0] qa);
        int        free;
        bit        ld_rdy, alu_rdy;
        wb_entry_t e;
        LdValid   = ldv;  LdAddr  = lda;  LdData  = ldd;
        AluValid  = aluv; AluAddr = alua; AluData = alud; AluJump = aluj;
        Reset     = rst;  QueryAddr = qa;
        #1;
        free    = DEPTH - mdl.size();
        ld_rdy  = !rst && free >= 1;
        alu_rdy = !rst && (free >= 2 || (free == 1 && !ldv));
        check("LdReady", int'(LdReady), int'(ld_rdy));
        check("AluReady", int'(AluReady), int'(alu_rdy));
        @(posedge Clk);
        if (rst) begin
            mdl.delete();
            exp_q.delete();
        end else begin
            if (mdl.size() > 0) void'(mdl.pop_front());
            if (ldv && ld_rdy) begin
                e = '{jump: 1'b0, addr: lda, data: ldd};
                mdl.push_back(e);
                exp_q.push_back(e);
            end
            if (aluv && alu_rdy) begin
                e = '{jump: aluj, addr: alua, data: alud};
                mdl.push_back(e);
                exp_q.push_back(e);
            end
        end
        #1;
        check("Count", int'(Count), mdl.size());
        check("CountBound", int'(Count <= 3'(DEPTH)), 1);
    endtask

    task automatic idle(input logic [A-1:0] qa);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, qa);
    endtask

    // Monitor: every cycle the register-file port must present the oldest pending write.
    always @(negedge Clk) begin
        wb_entry_t e;
        bit        qp;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("WriteEn", int'(WriteEn), 1);
                check("Waddr", int'(Waddr), int'(e.addr));
                check("DataIn", int'(DataIn), int'(e.data));
                check("Jump", int'(Jump), int'(e.jump));
            end else begin
                check("WriteEnIdle", int'(WriteEn), 0);
                check("WaddrIdle", int'(Waddr), 0);
                check("DataInIdle", int'(DataIn), 0);
                check("JumpIdle", int'(Jump), 0);
            end
            qp = 1'b0;
            foreach (mdl[i]) if (mdl[i].addr == QueryAddr && !mdl[i].jump) qp = 1'b1;
            check("QueryPending", int'(QueryPending), int'(qp));
        end
    end

    initial begin
        @(posedge Clk);
        #1;
        mon_en = 1'b1;
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, '0);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, '0);
        idle('0);

        // Single load on an idle queue.
        step(1'b1, 2'd2, 8'h5A, 1'b0, '0, '0, 1'b0, 1'b0, 2'd0);
        idle(2'd2);
        idle(2'd0);

        // Both sources on an empty queue: load first, then ALU.
        step(1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h22, 1'b0, 1'b0, 2'd1);
        idle(2'd3);
        idle(2'd0);
        idle(2'd0);

        // Fill to 3, then both valid: load wins the single slot.
        step(1'b1, 2'd0, 8'h01, 1'b1, 2'd1, 8'h02, 1'b0, 1'b0, 2'd0);
        step(1'b1, 2'd2, 8'h03, 1'b1, 2'd3, 8'h04, 1'b0, 1'b0, 2'd0);
        step(1'b1, 2'd1, 8'h05, 1'b1, 2'd2, 8'h06, 1'b0, 1'b0, 2'd0);
        repeat (4) idle(2'd0);

        // Jump-register write is not a hazard.
        step(1'b0, '0, '0, 1'b1, 2'd3, 8'h40, 1'b1, 1'b0, 2'd3);
        idle(2'd3);
        idle(2'd3);

        // Hazard probes, then reset discards pending writes.
        step(1'b1, 2'd0, 8'hA0, 1'b1, 2'd2, 8'hA2, 1'b0, 1'b0, 2'd2);
        step(1'b1, 2'd1, 8'hA1, 1'b1, 2'd3, 8'hA3, 1'b0, 1'b0, 2'd1);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 2'd2);
        idle(2'd2);
        idle(2'd0);

        // Back-to-back dual pushes across pointer wrap.
        for (int i = 0; i < 4 + DEPTH; i++) begin
            step(1'b1, A'(i), W'(8'h80 + i), 1'b1, A'(i + 1), W'(8'hC0 + i), 1'b0, 1'b0,
                 A'(i));
        end
        repeat (DEPTH + 1) idle(2'd0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 6), A'($urandom), W'($urandom),
                 1'($urandom_range(0, 9) < 6), A'($urandom), W'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 49) == 0), A'($urandom));
        end
        repeat (DEPTH + 1) idle(2'd0);
        check("DrainedCount", int'(Count), 0);

        @(posedge Clk);
        #1;
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
